// File: rtl/vx_tcache_rsp_merge_pkg.sv
// Shared tcache definitions: the slot-id width helper, the word-width helper and
// the per-slot bookkeeping record used by the response merge unit.
package vx_tcache_rsp_merge_pkg;

  localparam int TC_NUM_REQS  = 4;
  localparam int TC_WORD_SIZE = 4;
  localparam int TC_TAG_WIDTH = 8;
  localparam int TC_SLOTS     = 4;

  function automatic int tc_word_width(input int word_size);
    return 8 * word_size;
  endfunction

  function automatic int tc_id_width(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

  localparam int TC_ID_W = tc_id_width(TC_SLOTS);

  typedef logic [TC_ID_W-1:0] tc_slot_id_t;

  // busy: slot owns a request; sent: slot has been copied into the output stage.
  typedef struct packed {
    logic                    busy;
    logic                    sent;
    logic [TC_NUM_REQS-1:0]  pending;
    logic [TC_NUM_REQS-1:0]  tmask;
    logic [TC_TAG_WIDTH-1:0] tag;
  } tc_slot_t;

endpackage

// File: rtl/vx_tcache_rsp_order_fifo.sv
// Slot-id FIFO remembering allocation order. Pushed with the granted slot on
// alloc, popped when that slot is moved into the response stage.
module vx_tcache_rsp_order_fifo #(
  parameter int SLOTS = 4,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic            head_valid,
  output logic [ID_W-1:0] head_id
);

  logic [ID_W-1:0] mem_reg [SLOTS];
  logic [ID_W-1:0] rd_ptr_reg;
  logic [ID_W-1:0] wr_ptr_reg;
  logic [ID_W:0]   count_reg;

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return (p == ID_W'(SLOTS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count_reg != '0);
  assign head_id    = mem_reg[rd_ptr_reg];

  // Pointer and occupancy tracking; never overflows since ids come from free slots.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // Id storage; contents are only meaningful below count_reg so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= push_id;
  end

endmodule

// File: rtl/vx_tcache_rsp_merge.sv
// Texture-cache response merge: collects per-lane word returns into request
// slots and emits one merged response per request from a registered stage.
// Optional macro TCACHE_RSP_INORDER_EN: responses leave in allocation order;
// otherwise the lowest-index complete slot goes first.
module vx_tcache_rsp_merge
  import vx_tcache_rsp_merge_pkg::*;
#(
  parameter int NUM_REQS  = TC_NUM_REQS,
  parameter int WORD_SIZE = TC_WORD_SIZE,
  parameter int TAG_WIDTH = TC_TAG_WIDTH,
  parameter int SLOTS     = TC_SLOTS,
  localparam int WORD_WIDTH = tc_word_width(WORD_SIZE),
  localparam int ID_W       = tc_id_width(SLOTS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alloc_valid,
  input  logic [NUM_REQS-1:0]            alloc_tmask,
  input  logic [TAG_WIDTH-1:0]           alloc_tag,
  output logic                           alloc_ready,
  output logic [ID_W-1:0]                alloc_id,
  input  logic [NUM_REQS-1:0]            lane_rsp_valid,
  input  logic [NUM_REQS*ID_W-1:0]       lane_rsp_id,
  input  logic [NUM_REQS*WORD_WIDTH-1:0] lane_rsp_data,
  output logic [NUM_REQS-1:0]            lane_rsp_ready,
  output logic                           rsp_valid,
  output logic [NUM_REQS-1:0]            rsp_tmask,
  output logic [NUM_REQS*WORD_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  input  logic                           rsp_ready
);

  tc_slot_t              slot_reg [SLOTS];
  logic [WORD_WIDTH-1:0] data_reg [SLOTS][NUM_REQS];

  logic                           out_valid_reg;
  logic [NUM_REQS-1:0]            out_tmask_reg;
  logic [NUM_REQS*WORD_WIDTH-1:0] out_data_reg;
  logic [TAG_WIDTH-1:0]           out_tag_reg;
  logic [ID_W-1:0]                out_id_reg;

  logic [ID_W-1:0]                lane_id [NUM_REQS];
  logic [NUM_REQS-1:0]            lane_hit [SLOTS];
  logic [SLOTS-1:0]               free_vec;
  logic [SLOTS-1:0]               done_vec;
  logic [ID_W-1:0]                free_id;
  logic [ID_W-1:0]                sel_id;
  logic                           sel_valid;
  logic                           alloc_fire;
  logic                           rsp_fire;
  logic                           load_en;
  logic [NUM_REQS*WORD_WIDTH-1:0] load_data;

  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_lane_id
    assign lane_id[gi] = lane_rsp_id[gi*ID_W +: ID_W];
  end

  // A slot is eligible for output once all its lanes are in and it is not already staged.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot_state
    assign free_vec[gi] = ~slot_reg[gi].busy;
    assign done_vec[gi] = slot_reg[gi].busy & ~slot_reg[gi].sent & (slot_reg[gi].pending == '0);
  end

  // Lane returns only land on busy slots still waiting for that lane; others are dropped.
  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      lane_hit[s] = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        lane_hit[s][i] = lane_rsp_valid[i] && (lane_id[i] == ID_W'(s))
                      && slot_reg[s].busy && slot_reg[s].pending[i];
      end
    end
  end

  // Lowest-index free slot; a slot freed this cycle is still busy so it is never chosen.
  always_comb begin
    free_id = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (free_vec[s]) free_id = ID_W'(s);
    end
  end

`ifdef TCACHE_RSP_INORDER_EN
  logic            head_valid;
  logic [ID_W-1:0] head_id;

  vx_tcache_rsp_order_fifo #(
    .SLOTS (SLOTS),
    .ID_W  (ID_W)
  ) order_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (alloc_fire),
    .push_id    (free_id),
    .pop        (load_en),
    .head_valid (head_valid),
    .head_id    (head_id)
  );

  // Only the oldest outstanding slot may be staged; younger complete slots wait.
  always_comb begin
    sel_id    = head_id;
    sel_valid = head_valid && done_vec[head_id];
  end
`else
  // Out-of-order: stage the lowest-index complete slot.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (done_vec[s]) begin
        sel_valid = 1'b1;
        sel_id    = ID_W'(s);
      end
    end
  end
`endif

  assign alloc_ready    = |free_vec;
  assign alloc_id       = free_id;
  assign alloc_fire     = alloc_valid && alloc_ready;
  assign rsp_fire       = out_valid_reg && rsp_ready;
  assign load_en        = sel_valid && (!out_valid_reg || rsp_ready);
  assign lane_rsp_ready = '1;

  // Gather the selected slot's words, forcing inactive lanes to zero.
  always_comb begin
    load_data = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (slot_reg[sel_id].tmask[i]) load_data[i*WORD_WIDTH +: WORD_WIDTH] = data_reg[sel_id][i];
    end
  end

  // Slot lifecycle (alloc, lane clear, stage, free) and the registered response stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SLOTS; s++) slot_reg[s] <= '0;
      out_valid_reg <= 1'b0;
      out_tmask_reg <= '0;
      out_data_reg  <= '0;
      out_tag_reg   <= '0;
      out_id_reg    <= '0;
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        slot_reg[s].pending <= slot_reg[s].pending & ~lane_hit[s];
      end
      if (rsp_fire) begin
        slot_reg[out_id_reg].busy <= 1'b0;
        slot_reg[out_id_reg].sent <= 1'b0;
      end
      if (alloc_fire) begin
        slot_reg[free_id].busy    <= 1'b1;
        slot_reg[free_id].pending <= alloc_tmask;
        slot_reg[free_id].tmask   <= alloc_tmask;
        slot_reg[free_id].tag     <= alloc_tag;
      end
      if (load_en) begin
        slot_reg[sel_id].sent <= 1'b1;
        out_valid_reg         <= 1'b1;
        out_tmask_reg         <= slot_reg[sel_id].tmask;
        out_data_reg          <= load_data;
        out_tag_reg           <= slot_reg[sel_id].tag;
        out_id_reg            <= sel_id;
      end else if (rsp_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  // Word capture; readout is masked by tmask and gated by pending, so no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SLOTS; s++) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (lane_hit[s][i]) data_reg[s][i] <= lane_rsp_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign rsp_valid = out_valid_reg;
  assign rsp_tmask = out_tmask_reg;
  assign rsp_data  = out_data_reg;
  assign rsp_tag   = out_tag_reg;

endmodule

// File: tb/tb_vx_tcache_rsp_merge.sv
// Directed scenarios plus a randomized phase checked against a request-level
// scoreboard (free-slot set and per-request lane collection).
`timescale 1ns/1ps
module tb_vx_tcache_rsp_merge;

  localparam int NR = 4;
  localparam int WW = 32;
  localparam int TW = 8;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             alloc_valid = 1'b0;
  logic [NR-1:0]    alloc_tmask = '0;
  logic [TW-1:0]    alloc_tag = '0;
  logic             alloc_ready;
  logic [IW-1:0]    alloc_id;
  logic [NR-1:0]    lane_rsp_valid = '0;
  logic [NR*IW-1:0] lane_rsp_id = '0;
  logic [NR*WW-1:0] lane_rsp_data = '0;
  logic [NR-1:0]    lane_rsp_ready;
  logic             rsp_valid;
  logic [NR-1:0]    rsp_tmask;
  logic [NR*WW-1:0] rsp_data;
  logic [TW-1:0]    rsp_tag;
  logic             rsp_ready = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  vx_tcache_rsp_merge dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_valid    (alloc_valid),
    .alloc_tmask    (alloc_tmask),
    .alloc_tag      (alloc_tag),
    .alloc_ready    (alloc_ready),
    .alloc_id       (alloc_id),
    .lane_rsp_valid (lane_rsp_valid),
    .lane_rsp_id    (lane_rsp_id),
    .lane_rsp_data  (lane_rsp_data),
    .lane_rsp_ready (lane_rsp_ready),
    .rsp_valid      (rsp_valid),
    .rsp_tmask      (rsp_tmask),
    .rsp_data       (rsp_data),
    .rsp_tag        (rsp_tag),
    .rsp_ready      (rsp_ready)
  );

  typedef struct packed {
    logic [7:0]   tag;
    logic [3:0]   tmask;
    logic [3:0]   got;
    logic [127:0] data;
    int           id;
  } rec_t;

  rec_t       live[$];
  logic [7:0] next_tag;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] w3, input logic [31:0] w2,
                                         input logic [31:0] w1, input logic [31:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_valid    = 1'b0;
    lane_rsp_valid = '0;
    rsp_ready      = 1'b0;
    reset          = 1'b1;
    #2;
    reset          = 1'b0;
  endtask

  task automatic do_alloc(input logic [3:0] tm, input logic [7:0] tg, input logic [1:0] exp_id,
                          input string name);
    alloc_valid = 1'b1;
    alloc_tmask = tm;
    alloc_tag   = tg;
    chk({name, "_ready"}, alloc_ready, 1'b1);
    chk({name, "_id"}, alloc_id, exp_id);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic lanes(input logic [3:0] v, input logic [7:0] ids, input logic [127:0] d);
    lane_rsp_valid = v;
    lane_rsp_id    = ids;
    lane_rsp_data  = d;
    tick();
    lane_rsp_valid = '0;
  endtask

  // One random cycle: check DUT against the scoreboard, drive stimulus, update the model.
  task automatic rnd_cycle(input bit drain);
    int          exp_free;
    bit          occ[4];
    int          k;
    int          hit_k[4];
    int          s;
    int          hs_idx;
    bit          new_rec;
    logic [31:0] d[4];
    rec_t        r;
    for (int j = 0; j < 4; j++) occ[j] = 1'b0;
    foreach (live[q]) occ[live[q].id] = 1'b1;
    exp_free = -1;
    for (int j = 3; j >= 0; j--) if (!occ[j]) exp_free = j;
    chk("rnd_alloc_ready", alloc_ready, exp_free >= 0);
    if (exp_free >= 0) chk("rnd_alloc_id", alloc_id, exp_free[1:0]);

    rsp_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    hs_idx = -1;
    if (rsp_valid) begin
      k = -1;
      foreach (live[q]) if (live[q].tag == rsp_tag) k = q;
      chk("rnd_rsp_tag_known", k >= 0, 1'b1);
      if (k >= 0) begin
        chk("rnd_rsp_tmask", rsp_tmask, live[k].tmask);
        chk("rnd_rsp_data", rsp_data, live[k].data);
        chk("rnd_rsp_complete", live[k].got, live[k].tmask);
`ifdef TCACHE_RSP_INORDER_EN
        chk("rnd_rsp_order", k, 0);
`endif
        if (rsp_ready) hs_idx = k;
      end
    end

    for (int i = 0; i < 4; i++) begin
      hit_k[i] = -1;
      s = $urandom_range(0, 3);
      lane_rsp_valid[i] = ($urandom_range(0, 1) == 1);
      if (drain) begin
        foreach (live[q]) begin
          if (live[q].tmask[i] && !live[q].got[i]) begin
            s = live[q].id;
            lane_rsp_valid[i] = 1'b1;
          end
        end
      end
      d[i] = $urandom;
      lane_rsp_id[i*2 +: 2]    = s[1:0];
      lane_rsp_data[i*32 +: 32] = d[i];
      if (lane_rsp_valid[i]) begin
        foreach (live[q]) if (live[q].id == s && live[q].tmask[i] && !live[q].got[i]) hit_k[i] = q;
      end
    end

    alloc_valid = !drain && ($urandom_range(0, 1) == 1);
    alloc_tmask = 4'($urandom_range(0, 15));
    alloc_tag   = next_tag;
    new_rec     = alloc_valid && (exp_free >= 0);

    tick();

    for (int i = 0; i < 4; i++) begin
      if (hit_k[i] >= 0) begin
        r = live[hit_k[i]];
        r.got[i] = 1'b1;
        r.data[i*32 +: 32] = d[i];
        live[hit_k[i]] = r;
      end
    end
    if (hs_idx >= 0) live.delete(hs_idx);
    if (new_rec) begin
      r.tag   = alloc_tag;
      r.tmask = alloc_tmask;
      r.got   = '0;
      r.data  = '0;
      r.id    = exp_free;
      live.push_back(r);
      next_tag = next_tag + 8'd1;
    end
    alloc_valid    = 1'b0;
    lane_rsp_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int budget;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_alloc_ready", alloc_ready, 1'b1);
    chk("rst_alloc_id", alloc_id, 2'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_tmask", rsp_tmask, 4'b0);
    chk("rst_rsp_data", rsp_data, 128'h0);
    chk("rst_rsp_tag", rsp_tag, 8'h0);
    chk("rst_lane_ready", lane_rsp_ready, 4'hF);

    // Three lanes returning in separate cycles, with stray returns in between
    rsp_ready = 1'b1;
    do_alloc(4'b1011, 8'h5A, 2'd0, "s1_alloc");
    lanes(4'b0001, 8'h00, pack4(32'h0, 32'h0, 32'h0, 32'h11));
    lanes(4'b0101, 8'h00, pack4(32'h0, 32'hEE, 32'h0, 32'hEE));
    lanes(4'b0010, 8'h00, pack4(32'h0, 32'h0, 32'h22, 32'h0));
    lanes(4'b1000, 8'h00, pack4(32'h44, 32'h0, 32'h0, 32'h0));
    chk("s1_not_early", rsp_valid, 1'b0);
    tick();
    chk("s1_valid", rsp_valid, 1'b1);
    chk("s1_tmask", rsp_tmask, 4'b1011);
    chk("s1_data", rsp_data, pack4(32'h44, 32'h0, 32'h22, 32'h11));
    chk("s1_tag", rsp_tag, 8'h5A);
    tick();
    chk("s1_done", rsp_valid, 1'b0);
    chk("s1_freed_ready", alloc_ready, 1'b1);
    chk("s1_freed_id", alloc_id, 2'd0);

    // Fill all slots, back-pressure, single handshake
    do_reset();
    for (int k = 0; k < 4; k++) do_alloc(4'b0001, 8'(8'h10 + k), 2'(k), "s2_alloc");
    chk("s2_full", alloc_ready, 1'b0);
    lanes(4'b0001, 8'h00, pack4(32'h0, 32'h0, 32'h0, 32'h1234));
    chk("s2_not_early", rsp_valid, 1'b0);
    tick();
    chk("s2_valid", rsp_valid, 1'b1);
    chk("s2_tag", rsp_tag, 8'h10);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("s2_hold_valid", rsp_valid, 1'b1);
      chk("s2_hold_tag", rsp_tag, 8'h10);
      chk("s2_hold_tmask", rsp_tmask, 4'b0001);
      chk("s2_hold_data", rsp_data, pack4(32'h0, 32'h0, 32'h0, 32'h1234));
      chk("s2_still_full", alloc_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("s2_after_hs_valid", rsp_valid, 1'b0);
    chk("s2_after_hs_ready", alloc_ready, 1'b1);
    chk("s2_after_hs_id", alloc_id, 2'd0);
    tick();
    chk("s2_no_dup", rsp_valid, 1'b0);

    // Ordering: slot 1 completes while slot 0 is still waiting on lane 0
    do_reset();
    rsp_ready = 1'b1;
    do_alloc(4'b0011, 8'hA0, 2'd0, "s3_alloc0");
    do_alloc(4'b0001, 8'hB1, 2'd1, "s3_alloc1");
    lanes(4'b0011, 8'b0000_0001, pack4(32'h0, 32'h0, 32'hA1, 32'hB));
    tick();
`ifdef TCACHE_RSP_INORDER_EN
    chk("s3_young_held", rsp_valid, 1'b0);
`else
    chk("s3_young_first", rsp_valid, 1'b1);
    chk("s3_young_tag", rsp_tag, 8'hB1);
    chk("s3_young_data", rsp_data, pack4(32'h0, 32'h0, 32'h0, 32'hB));
`endif
    lanes(4'b0001, 8'h00, pack4(32'h0, 32'h0, 32'h0, 32'hA0));
    chk("s3_gap", rsp_valid, 1'b0);
    tick();
    chk("s3_old_valid", rsp_valid, 1'b1);
    chk("s3_old_tag", rsp_tag, 8'hA0);
    chk("s3_old_tmask", rsp_tmask, 4'b0011);
    chk("s3_old_data", rsp_data, pack4(32'h0, 32'h0, 32'hA1, 32'hA0));
    tick();
`ifdef TCACHE_RSP_INORDER_EN
    chk("s3_young_b2b", rsp_valid, 1'b1);
    chk("s3_young_tag2", rsp_tag, 8'hB1);
    chk("s3_young_data2", rsp_data, pack4(32'h0, 32'h0, 32'h0, 32'hB));
`else
    chk("s3_empty", rsp_valid, 1'b0);
`endif
    tick();
    chk("s3_drained", rsp_valid, 1'b0);

    // Empty tmask, then a stray return to a free slot
    do_reset();
    do_alloc(4'b0000, 8'h77, 2'd0, "s4_alloc");
    chk("s4_not_early", rsp_valid, 1'b0);
    tick();
    chk("s4_valid", rsp_valid, 1'b1);
    chk("s4_tmask", rsp_tmask, 4'b0000);
    chk("s4_data", rsp_data, 128'h0);
    chk("s4_tag", rsp_tag, 8'h77);
    rsp_ready = 1'b1;
    lanes(4'b0100, 8'h30, pack4(32'h0, 32'hDEAD, 32'h0, 32'h0));
    chk("s4_after_hs", rsp_valid, 1'b0);
    tick();
    tick();
    chk("s4_stray_ignored", rsp_valid, 1'b0);
    chk("s4_ready", alloc_ready, 1'b1);
    chk("s4_id", alloc_id, 2'd0);

    // Reset in the middle of traffic
    do_reset();
    do_alloc(4'b0001, 8'hC0, 2'd0, "s5_alloc0");
    do_alloc(4'b1111, 8'hC1, 2'd1, "s5_alloc1");
    do_alloc(4'b1111, 8'hC2, 2'd2, "s5_alloc2");
    lanes(4'b0011, 8'b0000_0100, pack4(32'h0, 32'h0, 32'h77, 32'h5));
    tick();
    chk("s5_pre_valid", rsp_valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("s5_rst_valid", rsp_valid, 1'b0);
    chk("s5_rst_ready", alloc_ready, 1'b1);
    chk("s5_rst_id", alloc_id, 2'd0);
    chk("s5_rst_tag", rsp_tag, 8'h0);
    chk("s5_rst_data", rsp_data, 128'h0);
    #1;
    reset = 1'b0;
    tick();
    rsp_ready = 1'b1;
    lanes(4'b1111, 8'b0101_0101, pack4(32'h1, 32'h2, 32'h3, 32'h4));
    lanes(4'b1111, 8'b1010_1010, pack4(32'h5, 32'h6, 32'h7, 32'h8));
    lanes(4'b0001, 8'h00, pack4(32'h0, 32'h0, 32'h0, 32'h9));
    for (int c = 0; c < 3; c++) begin
      chk("s5_late_ignored", rsp_valid, 1'b0);
      chk("s5_late_ready", alloc_ready, 1'b1);
      tick();
    end

    // Randomized traffic against the scoreboard, then drain
    do_reset();
    live.delete();
    next_tag = 8'h80;
    for (int c = 0; c < 400; c++) rnd_cycle(1'b0);
    budget = 0;
    while ((live.size() != 0 || rsp_valid) && budget < 300) begin
      rnd_cycle(1'b1);
      budget++;
    end
    chk("rnd_drained", live.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
